serializer_vrtl: RTL and testbench
==================================

Name: serializer_vrtl

Overview:
- Parallel-to-serial converter; the transmit-side counterpart of the team's deserializer.
- Accepts one frame of N_SAMPLES words in a single val/rdy transaction.
- Emits the frame one word per handshake on a BIT_WIDTH val/rdy stream, index 0 first.
- Chaining serializer -> deserializer with equal parameters reproduces the frame unchanged, index for index. Used to stream sample blocks from a parallel compute stage onto a narrow link.

Parameters:
- N_SAMPLES, 8, words per frame; must be ≥ 2 and a power of two.
- BIT_WIDTH, 32, width of each word in bits.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- recv_val  input  1  parallel frame valid.
- recv_rdy  output  1  serializer can accept a frame.
- recv_msg  input  BIT_WIDTH x [N_SAMPLES-1:0] (unpacked array)  parallel frame; element i is the i-th word sent.
- send_val  output  1  serial word valid.
- send_rdy  input  1  downstream accepts word.
- send_msg  output  BIT_WIDTH  current serial word.

Behaviour:
- Storage:
  - Frame buffer buf[N_SAMPLES-1:0] of BIT_WIDTH registers.
  - Index counter idx of width $clog2(N_SAMPLES).
  - 1-bit state: IDLE=0, SEND=1.
- Reset, synchronous, has priority over everything:
  - Clears the state to IDLE, idx to 0 and all buf entries to 0.
  - Outputs after reset: recv_rdy=1, send_val=0, send_msg=0.
  - Reset mid-frame discards all remaining words; no further send_val until a new frame is accepted.
- Transfer events:
  - Accept = recv_val & recv_rdy.
  - Xfer = send_val & send_rdy.
- IDLE:
  - Outputs: send_val=0, recv_rdy=1.
  - On accept: all N_SAMPLES words are written to buf in the same edge, idx <= 0, state <= SEND.
  - Without accept: state, idx and buf hold.
- SEND:
  - Outputs: send_val=1, send_msg=buf[idx].
  - On xfer with idx < N_SAMPLES-1: idx <= idx+1.
  - Without xfer: everything holds. send_msg must remain stable while send_val=1 and send_rdy=0.
  - On xfer with idx == N_SAMPLES-1 (last word): frame is complete.
    - If accept occurs in that same cycle: buf is reloaded, idx <= 0, state stays SEND. There is no bubble between frames.
    - Otherwise: idx <= 0, state <= IDLE.
- recv_rdy:
  - 1 in IDLE.
  - In SEND: 1 only when idx == N_SAMPLES-1 and send_rdy == 1; 0 otherwise.
  - This is the only combinational input-to-output path, send_rdy -> recv_rdy.
- recv_val while recv_rdy=0 has no effect. recv_msg is sampled only on accept.
- send_msg is buf[idx] in every state, including IDLE. In IDLE it is don't-care for consumers but deterministic.
- Latency:
  - First word is valid on the cycle after accept.
  - An uninterrupted frame takes exactly N_SAMPLES cycles of send_val=1.
  - Peak throughput is one word per cycle, sustained across back-to-back frames.
- idx never wraps through an invalid value; it returns to 0 only via frame completion or reset.

Test Plan:
- Single frame, N_SAMPLES=8, BIT_WIDTH=32, recv_msg[i]=0x10+i, send_rdy held 1:
  - recv_rdy=1 in the accept cycle, then 0.
  - send_val=1 for exactly 8 consecutive cycles starting one cycle after accept, send_msg=0x10..0x17 in order.
  - Then IDLE with recv_rdy=1.
- Backpressure: same frame, send_rdy toggled 1,0,0,1,0,1,...:
  - Each word is held stable while stalled.
  - Exactly 8 xfers occur, values 0x10..0x17, with no duplicates or drops.
- Back-to-back: frame A = 0xA0..0xA7, with frame B = 0xB0..0xB7 presented with recv_val=1 throughout:
  - recv_rdy pulses in the cycle of A's last xfer.
  - 16 consecutive send_val=1 cycles carry A then B.
  - No idle cycle between 0xA7 and 0xB0.
- Ignored input: while in SEND with idx<7, assert recv_val with a different recv_msg:
  - Output stream is unchanged.
  - recv_rdy stays 0 until the last word.
- Reset mid-frame: assert reset after 3 xfers:
  - Next cycle: send_val=0, recv_rdy=1, send_msg=0.
  - A new frame 0x20..0x27 then emits from 0x20.
- Loopback: serializer -> deserializer (same parameters), random frames and random send_rdy/recv_val stalls over 100 frames:
  - Each deserializer output array equals the corresponding serializer input array element-wise.

Source files
------------

// File: rtl/serializer_vrtl.sv
// Parallel-to-serial converter: one N_SAMPLES-word frame in, N_SAMPLES
// BIT_WIDTH words out on a val/rdy stream, index 0 first, no bubble between frames.

module serializer_vrtl_word #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [BIT_WIDTH-1:0] d,
  output logic [BIT_WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
  end

endmodule

module serializer_vrtl #(
  parameter int N_SAMPLES = 8,
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES],
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [BIT_WIDTH-1:0] send_msg
);

  localparam int IW = $clog2(N_SAMPLES);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_SAMPLES - 1);

  logic [0:0]           state;
  logic [IW-1:0]        idx;
  logic [BIT_WIDTH-1:0] words [N_SAMPLES];
  logic                 accept, xfer, last;

  assign last     = (idx == LAST_IDX);
  assign send_val = (state == SEND);
  // Ready in SEND only as the last word leaves, so the next frame lands with no gap.
  assign recv_rdy = (state == IDLE) | (last & send_rdy);
  assign accept   = recv_val & recv_rdy;
  assign xfer     = send_val & send_rdy;
  assign send_msg = words[idx];

  for (genvar i = 0; i < N_SAMPLES; i++) begin : g_word
    serializer_vrtl_word #(.BIT_WIDTH(BIT_WIDTH)) u_word (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .d     (recv_msg[i]),
      .q     (words[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= SEND;
            idx   <= '0;
          end
        end
        default: begin
          if (xfer) begin
            if (!last) begin
              idx <= idx + 1'b1;
            end else begin
              idx   <= '0;
              state <= accept ? SEND : IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_vrtl.sv
// Directed and randomized-loopback checks for serializer_vrtl (N_SAMPLES=8, BIT_WIDTH=32).

module tb_serializer_vrtl;

  localparam int N = 8;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         recv_val;
  logic         recv_rdy;
  logic [W-1:0] recv_msg [N];
  logic         send_val;
  logic         send_rdy;
  logic [W-1:0] send_msg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         sr;
    logic         exp_val;
    logic [W-1:0] exp_msg;
    logic         exp_rrdy;
  } vec_t;

  vec_t bp [14];

  serializer_vrtl #(.N_SAMPLES(N), .BIT_WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .recv_msg (recv_msg),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .send_msg (send_msg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Inputs change in the low phase; outputs are sampled 1ns later, before the next rising edge.
  task automatic drive(input logic rv, input logic sr, input logic [W-1:0] base);
    @(negedge clk);
    recv_val = rv;
    send_rdy = sr;
    for (int i = 0; i < N; i++) recv_msg[i] = base + W'(i);
    #1;
  endtask

  initial begin
    // send_rdy pattern 1,0,0,1,0,1,1,0,1,0,0,1,1,1 with the word expected in each cycle
    bp[0]  = '{1'b1, 1'b1, 32'h10, 1'b0};
    bp[1]  = '{1'b0, 1'b1, 32'h11, 1'b0};
    bp[2]  = '{1'b0, 1'b1, 32'h11, 1'b0};
    bp[3]  = '{1'b1, 1'b1, 32'h11, 1'b0};
    bp[4]  = '{1'b0, 1'b1, 32'h12, 1'b0};
    bp[5]  = '{1'b1, 1'b1, 32'h12, 1'b0};
    bp[6]  = '{1'b1, 1'b1, 32'h13, 1'b0};
    bp[7]  = '{1'b0, 1'b1, 32'h14, 1'b0};
    bp[8]  = '{1'b1, 1'b1, 32'h14, 1'b0};
    bp[9]  = '{1'b0, 1'b1, 32'h15, 1'b0};
    bp[10] = '{1'b0, 1'b1, 32'h15, 1'b0};
    bp[11] = '{1'b1, 1'b1, 32'h15, 1'b0};
    bp[12] = '{1'b1, 1'b1, 32'h16, 1'b0};
    bp[13] = '{1'b1, 1'b1, 32'h17, 1'b1};

    reset = 1'b1; recv_val = 1'b0; send_rdy = 1'b0;
    for (int i = 0; i < N; i++) recv_msg[i] = '0;
    drive(1'b0, 1'b1, 32'h0);
    drive(1'b0, 1'b1, 32'h0);
    reset = 1'b0;
    chk("reset_recv_rdy", W'(recv_rdy), 32'd1);
    chk("reset_send_val", W'(send_val), 32'd0);
    chk("reset_send_msg", send_msg, 32'd0);

    // Single frame, no stalls
    drive(1'b1, 1'b1, 32'h10);
    chk("single_accept_rdy", W'(recv_rdy), 32'd1);
    chk("single_accept_val", W'(send_val), 32'd0);
    for (int i = 0; i < N; i++) begin
      drive(1'b0, 1'b1, 32'h0);
      chk("single_val", W'(send_val), 32'd1);
      chk("single_msg", send_msg, 32'h10 + W'(i));
      chk("single_rrdy", W'(recv_rdy), (i == N - 1) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 1'b1, 32'h0);
    chk("single_done_val", W'(send_val), 32'd0);
    chk("single_done_rrdy", W'(recv_rdy), 32'd1);

    // Backpressure
    drive(1'b1, 1'b0, 32'h10);
    for (int k = 0; k < 14; k++) begin
      drive(1'b0, bp[k].sr, 32'h0);
      chk("bp_val", W'(send_val), W'(bp[k].exp_val));
      chk("bp_msg", send_msg, bp[k].exp_msg);
      chk("bp_rrdy", W'(recv_rdy), W'(bp[k].exp_rrdy));
    end
    drive(1'b0, 1'b1, 32'h0);
    chk("bp_done_val", W'(send_val), 32'd0);

    // Back-to-back frames A then B, B held valid until taken
    drive(1'b1, 1'b1, 32'hA0);
    for (int i = 0; i < N; i++) begin
      drive(1'b1, 1'b1, 32'hB0);
      chk("b2b_a_val", W'(send_val), 32'd1);
      chk("b2b_a_msg", send_msg, 32'hA0 + W'(i));
      chk("b2b_a_rrdy", W'(recv_rdy), (i == N - 1) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < N; i++) begin
      drive(1'b0, 1'b1, 32'h0);
      chk("b2b_b_val", W'(send_val), 32'd1);
      chk("b2b_b_msg", send_msg, 32'hB0 + W'(i));
    end
    drive(1'b0, 1'b1, 32'h0);
    chk("b2b_done_val", W'(send_val), 32'd0);

    // recv_val while busy must be ignored
    drive(1'b1, 1'b1, 32'h10);
    for (int i = 0; i < N; i++) begin
      drive(i < N - 1, 1'b1, 32'hE0);
      chk("ign_msg", send_msg, 32'h10 + W'(i));
      chk("ign_rrdy", W'(recv_rdy), (i == N - 1) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 1'b1, 32'h0);
    chk("ign_done_val", W'(send_val), 32'd0);

    // Reset after three transfers
    drive(1'b1, 1'b1, 32'h30);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'h0);
    drive(1'b0, 1'b1, 32'h0);
    chk("rst_mid_pre_msg", send_msg, 32'h33);
    reset = 1'b1;
    drive(1'b0, 1'b1, 32'h0);
    reset = 1'b0;
    chk("rst_mid_val", W'(send_val), 32'd0);
    chk("rst_mid_rrdy", W'(recv_rdy), 32'd1);
    chk("rst_mid_msg", send_msg, 32'd0);
    drive(1'b0, 1'b1, 32'h0);
    chk("rst_mid_stays_idle", W'(send_val), 32'd0);
    drive(1'b1, 1'b1, 32'h20);
    drive(1'b0, 1'b1, 32'h0);
    chk("rst_new_val", W'(send_val), 32'd1);
    chk("rst_new_msg", send_msg, 32'h20);
    for (int i = 1; i < N; i++) drive(1'b0, 1'b1, 32'h0);
    chk("rst_new_last_msg", send_msg, 32'h27);

    // Loopback: the bench acts as the deserializer and compares word by word
    begin
      logic [W-1:0] exp_q [$];
      int sent = 0;
      int got  = 0;
      int cyc  = 0;
      logic [W-1:0] exp_w;
      while (got < 100 * N && cyc < 20000) begin
        @(negedge clk);
        recv_val = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
        send_rdy = 1'($urandom_range(0, 1));
        for (int i = 0; i < N; i++) recv_msg[i] = $urandom;
        #1;
        if (recv_val && recv_rdy) begin
          for (int i = 0; i < N; i++) exp_q.push_back(recv_msg[i]);
          sent++;
        end
        if (send_val && send_rdy) begin
          if (exp_q.size() == 0) begin
            chk("loop_underflow", send_msg, 32'hxxxxxxxx);
          end else begin
            exp_w = exp_q.pop_front();
            chk("loop_word", send_msg, exp_w);
          end
          got++;
        end
        cyc++;
      end
      chk("loop_word_count", W'(got), W'(100 * N));
      chk("loop_queue_empty", W'(exp_q.size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
